// File: rtl/melody_pkg.sv
// Shared types, note table and default melody for the buzzer melody sequencer.
package melody_pkg;

  localparam int HP_W    = 16;
  localparam int DUR_W   = 6;
  localparam int MEL_LEN = 32;

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, CLICK, DONE} state_e;

  // One melody step: half-period in clk cycles (0 = rest), duration in ticks
  // (0 behaves as 1), and a flag marking the final step of the tune.
  typedef struct packed {
    logic [HP_W-1:0]  hp;
    logic [DUR_W-1:0] dur;
    logic             last;
  } entry_t;

  typedef entry_t [MEL_LEN-1:0] rom_t;

  // Half-periods at a 1 MHz clock.
  localparam logic [HP_W-1:0] NOTE_G4 = 16'd1275;
  localparam logic [HP_W-1:0] NOTE_A4 = 16'd1136;
  localparam logic [HP_W-1:0] NOTE_B4 = 16'd1012;
  localparam logic [HP_W-1:0] NOTE_C5 = 16'd955;
  localparam logic [HP_W-1:0] NOTE_D5 = 16'd851;
  localparam logic [HP_W-1:0] NOTE_E5 = 16'd758;
  localparam logic [HP_W-1:0] NOTE_G5 = 16'd637;
  localparam logic [HP_W-1:0] REST    = 16'd0;

  localparam int CLICK_HP_CYC   = 379;
  localparam int CLICK_TICK_CNT = 2;

  function automatic entry_t mk_note(input logic [HP_W-1:0] hp, input int dur, input logic last);
    entry_t e;
    e.hp   = hp;
    e.dur  = DUR_W'(dur);
    e.last = last;
    return e;
  endfunction

  // Short "you won" jingle; unused tail entries stay zero.
  function automatic rom_t build_rom();
    rom_t r;
    r     = '0;
    r[0]  = mk_note(NOTE_E5, 4, 1'b0);
    r[1]  = mk_note(NOTE_G5, 4, 1'b0);
    r[2]  = mk_note(NOTE_E5, 2, 1'b0);
    r[3]  = mk_note(NOTE_C5, 2, 1'b0);
    r[4]  = mk_note(NOTE_D5, 2, 1'b0);
    r[5]  = mk_note(NOTE_G4, 4, 1'b0);
    r[6]  = mk_note(REST,    2, 1'b0);
    r[7]  = mk_note(NOTE_A4, 2, 1'b0);
    r[8]  = mk_note(NOTE_B4, 2, 1'b0);
    r[9]  = mk_note(NOTE_C5, 8, 1'b1);
    return r;
  endfunction

  localparam rom_t MELODY_ROM = build_rom();

endpackage

// File: rtl/melody_sequencer_if.sv
// Control/status bundle between the dice control FSM (master) and the
// melody sequencer (slave).
interface melody_sequencer_if #(
  parameter int IW = 5
) ();
  logic          start;
  logic          stop;
  logic          loop_en;
  logic          click_req;
  logic          beep;
  logic          busy;
  logic          done;
  logic [IW-1:0] note_idx;

  modport master (
    output start, stop, loop_en, click_req,
    input  beep, busy, done, note_idx
  );

  modport slave (
    input  start, stop, loop_en, click_req,
    output beep, busy, done, note_idx
  );
endinterface

// File: rtl/melody_sequencer_tone_gen.sv
// Square-wave generator: beep holds each level for hp cycles while enabled.
module tone_gen
  import melody_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [HP_W-1:0] hp,
  output logic            beep
);

  logic [HP_W-1:0] cnt_q, cnt_d;
  logic [HP_W-1:0] hp_q, hp_d;
  logic            beep_q, beep_d;
  logic            act_q, act_d;

  // Next-state: silent when disabled or resting, restart high on enable or
  // on a new half-period, otherwise toggle after hp cycles at each level.
  always_comb begin
    cnt_d  = cnt_q;
    hp_d   = hp_q;
    beep_d = beep_q;
    act_d  = act_q;
    if (!en || hp == '0) begin
      cnt_d  = '0;
      beep_d = 1'b0;
      act_d  = 1'b0;
    end else if (!act_q || hp != hp_q) begin
      cnt_d  = '0;
      beep_d = 1'b1;
      act_d  = 1'b1;
      hp_d   = hp;
    end else if (cnt_q == hp - HP_W'(1)) begin
      cnt_d  = '0;
      beep_d = ~beep_q;
    end else begin
      cnt_d  = cnt_q + HP_W'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      hp_q   <= '0;
      beep_q <= 1'b0;
      act_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hp_q   <= hp_d;
      beep_q <= beep_d;
      act_q  <= act_d;
    end
  end

  assign beep = beep_q;

endmodule

// File: rtl/melody_sequencer.sv
// Table-driven buzzer controller: walks the note ROM, inserts a silent gap
// after every note, supports stop, looping and an idle key-click.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int               TICK_CYC    = 25000,
  parameter int               LEN         = MEL_LEN,
  parameter int               GAP_TICKS   = 1,
  parameter int               CLICK_HP    = CLICK_HP_CYC,
  parameter int               CLICK_TICKS = CLICK_TICK_CNT,
  parameter entry_t [LEN-1:0] ROM         = MELODY_ROM
) (
  input  logic               clk,
  input  logic               rst,
  melody_sequencer_if.slave  bus
);

  localparam int              IW        = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int              TW        = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_CYC - 1);
  localparam logic [IW-1:0]   IDX_LAST  = IW'(LEN - 1);
  localparam logic [7:0]      GAP_T     = 8'(GAP_TICKS);
  localparam logic [7:0]      CLICK_T   = 8'(CLICK_TICKS);
  localparam logic [HP_W-1:0] CLICK_HPV = HP_W'(CLICK_HP);

  state_e        state_q, state_d;
  logic [IW-1:0] note_idx_q, note_idx_d;
  entry_t        entry_q, entry_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [7:0]    dcnt_q, dcnt_d;
  logic          busy_q, done_q;

  logic            tick_wrap;
  logic [7:0]      dur_tgt;
  logic            tone_en;
  logic [HP_W-1:0] tone_hp;

  // Next-state logic: FSM transitions plus tick/duration counting.
  always_comb begin
    state_d    = state_q;
    note_idx_d = note_idx_q;
    entry_d    = entry_q;
    tick_d     = tick_q;
    dcnt_d     = dcnt_q;
    tick_wrap  = (tick_q == TICK_LAST);
    dur_tgt    = (entry_q.dur == '0) ? 8'd1 : {2'b00, entry_q.dur};

    if (state_q == PLAY || state_q == GAP || state_q == CLICK) begin
      tick_d = tick_wrap ? '0 : tick_q + TW'(1);
      if (tick_wrap) dcnt_d = dcnt_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = LOAD;
          note_idx_d = '0;
        end else if (bus.click_req) begin
          state_d = CLICK;
          tick_d  = '0;
          dcnt_d  = '0;
        end
      end
      LOAD: begin
        entry_d = ROM[note_idx_q];
        tick_d  = '0;
        dcnt_d  = '0;
        state_d = PLAY;
      end
      PLAY: begin
        if (tick_wrap && (dcnt_q + 8'd1) == dur_tgt) begin
          state_d = GAP;
          dcnt_d  = '0;
        end
      end
      GAP: begin
        if (tick_wrap && (dcnt_q + 8'd1) == GAP_T) begin
          dcnt_d = '0;
          if (entry_q.last || note_idx_q == IDX_LAST) begin
            if (bus.loop_en) begin
              note_idx_d = '0;
              state_d    = LOAD;
            end else begin
              state_d = DONE;
            end
          end else begin
            note_idx_d = note_idx_q + IW'(1);
            state_d    = LOAD;
          end
        end
      end
      CLICK: begin
        if (tick_wrap && (dcnt_q + 8'd1) == CLICK_T) state_d = IDLE;
      end
      DONE: begin
        state_d    = IDLE;
        note_idx_d = '0;
      end
      default: state_d = IDLE;
    endcase

    // stop overrides everything, including a same-cycle start.
    if (bus.stop) begin
      state_d    = IDLE;
      note_idx_d = '0;
    end

    if (state_d == IDLE) begin
      tick_d = '0;
      dcnt_d = '0;
    end
  end

  // Tone is driven from the next state so beep starts and stops on the same
  // edge as the state change rather than one cycle late.
  always_comb begin
    tone_en = (state_d == PLAY) || (state_d == CLICK);
    tone_hp = (state_d == CLICK) ? CLICK_HPV : entry_d.hp;
  end

  // State and registered outputs with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      note_idx_q <= '0;
      entry_q    <= '0;
      tick_q     <= '0;
      dcnt_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      note_idx_q <= note_idx_d;
      entry_q    <= entry_d;
      tick_q     <= tick_d;
      dcnt_q     <= dcnt_d;
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
    end
  end

  tone_gen u_tone (
    .clk  (clk),
    .rst  (rst),
    .en   (tone_en),
    .hp   (tone_hp),
    .beep (bus.beep)
  );

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.note_idx = note_idx_q;

endmodule
